// File: rtl/regfile_pkg.sv
// Shared register-file types and helpers for the operand fetch stage.
package regfile_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam int unsigned STAT_W   = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fetch_state_t;

    // True when the write-back enable for addr is set this cycle.
    function automatic logic onehot_hit(input logic [NUM_REGS-1:0] enable,
                                        input reg_addr_t           addr);
        return enable[addr];
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue/result bundle between register bank, operand fetch and ALU stage.
interface operand_fetch_if;
    import regfile_pkg::*;

    logic [NUM_REGS*DATA_W-1:0] regs_in;
    reg_data_t                  wb_data;
    logic [NUM_REGS-1:0]        wb_enable;
    logic                       in_valid;
    logic                       in_ready;
    reg_addr_t                  src_a;
    reg_addr_t                  src_b;
    reg_addr_t                  dst_in;
    logic                       out_valid;
    logic                       out_ready;
    reg_data_t                  op_a;
    reg_data_t                  op_b;
    reg_addr_t                  dst_out;

    modport slave (
        input  regs_in, wb_data, wb_enable, in_valid, src_a, src_b, dst_in, out_ready,
        output in_ready, out_valid, op_a, op_b, dst_out
    );

    modport master (
        output regs_in, wb_data, wb_enable, in_valid, src_a, src_b, dst_in, out_ready,
        input  in_ready, out_valid, op_a, op_b, dst_out
    );

endinterface

// File: rtl/operand_select.sv
// Address-to-value mux with same-cycle write-back bypass and optional hard-zero r0.
module operand_select
    import regfile_pkg::*;
#(
    parameter bit ZERO_REG0 = 1'b0
) (
    input  logic [NUM_REGS*DATA_W-1:0] i_regs,
    input  reg_data_t                  i_wb_data,
    input  logic [NUM_REGS-1:0]        i_wb_enable,
    input  reg_addr_t                  i_addr,
    output reg_data_t                  o_value_c
);

    // Bank value, overridden by the write that lands on the same edge, then by hard-zero r0.
    always_comb begin
        o_value_c = i_regs[32'(i_addr) * DATA_W +: DATA_W];
        if (onehot_hit(i_wb_enable, i_addr)) begin
            o_value_c = i_wb_data;
        end
        if (ZERO_REG0 && (i_addr == '0)) begin
            o_value_c = '0;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: picks two source operands (with write-back bypass) and
// holds them in a one-entry valid/ready output register.
// Optional build macro OPFETCH_STATS_EN adds issue_count/stall_count outputs.
module operand_fetch
    import regfile_pkg::*;
#(
    parameter bit ZERO_REG0 = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    operand_fetch_if.slave      bus
`ifdef OPFETCH_STATS_EN
    ,
    output logic [STAT_W-1:0]   issue_count,
    output logic [STAT_W-1:0]   stall_count
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic         w_issue;
    reg_data_t    w_op_a;
    reg_data_t    w_op_b;
    reg_data_t    r_op_a;
    reg_data_t    r_op_b;
    reg_addr_t    r_dst;

    operand_select #(.ZERO_REG0(ZERO_REG0)) u_sel_a (
        .i_regs      (bus.regs_in),
        .i_wb_data   (bus.wb_data),
        .i_wb_enable (bus.wb_enable),
        .i_addr      (bus.src_a),
        .o_value_c   (w_op_a)
    );

    operand_select #(.ZERO_REG0(ZERO_REG0)) u_sel_b (
        .i_regs      (bus.regs_in),
        .i_wb_data   (bus.wb_data),
        .i_wb_enable (bus.wb_enable),
        .i_addr      (bus.src_b),
        .o_value_c   (w_op_b)
    );

    // Next state and issue decision for the one-entry output register.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (bus.in_valid) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        w_issue = 1'b1;
                    end else begin
                        w_state_next = ST_EMPTY;
                    end
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand snapshot, loaded only on an issue so stalled data stays frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_dst  <= '0;
        end else if (w_issue) begin
            r_op_a <= w_op_a;
            r_op_b <= w_op_b;
            r_dst  <= bus.dst_in;
        end
    end

    assign bus.in_ready  = (r_state == ST_EMPTY) || bus.out_ready;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.dst_out   = r_dst;

`ifdef OPFETCH_STATS_EN
    logic [STAT_W-1:0] r_issue_count;
    logic [STAT_W-1:0] r_stall_count;

    // Free-running wrap-around counters for issues and downstream back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_issue) begin
                r_issue_count <= r_issue_count + STAT_W'(1);
            end
            if ((r_state == ST_FULL) && !bus.out_ready) begin
                r_stall_count <= r_stall_count + STAT_W'(1);
            end
        end
    end

    assign issue_count = r_issue_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; also checks counters when OPFETCH_STATS_EN is defined.
module tb_operand_fetch;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;

    operand_fetch_if bus ();
    operand_fetch_if bus_z ();

`ifdef OPFETCH_STATS_EN
    logic [15:0] issue_count, stall_count;
    logic [15:0] issue_count_z, stall_count_z;
`endif

    operand_fetch #(.ZERO_REG0(1'b0)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus)
`ifdef OPFETCH_STATS_EN
        ,
        .issue_count (issue_count),
        .stall_count (stall_count)
`endif
    );

    operand_fetch #(.ZERO_REG0(1'b1)) u_dut_z (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_z)
`ifdef OPFETCH_STATS_EN
        ,
        .issue_count (issue_count_z),
        .stall_count (stall_count_z)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Background register contents used outside the specific vectors.
    function automatic logic [15:0] rv(input int k);
        return 16'(k * 4097 + 16'h0F00);
    endfunction

    task automatic load_regs();
        for (int i = 0; i < 16; i++) begin
            bus.regs_in[i*16 +: 16]   = rv(i);
            bus_z.regs_in[i*16 +: 16] = rv(i);
        end
    endtask

    // Back-to-back vectors: src_a, src_b, wb_enable, wb_data, expected op_a, op_b.
    logic [3:0]  v_sa [7];
    logic [3:0]  v_sb [7];
    logic [15:0] v_we [7];
    logic [15:0] v_wd [7];
    logic [15:0] v_ea [7];
    logic [15:0] v_eb [7];

    initial begin
        v_sa = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd6, 4'd0};
        v_sb = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd4, 4'd6, 4'd9};
        v_we = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0014, 16'h0000, 16'h0001};
        v_wd = '{16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'h5A5A, 16'hDEAD, 16'h7777};
        v_ea = '{16'h0F00, 16'h1F01, 16'h2F02, 16'h3F03, 16'h5A5A, 16'h6F06, 16'h7777};
        v_eb = '{16'hFF0F, 16'hEF0E, 16'hDF0D, 16'hCF0C, 16'h5A5A, 16'h6F06, 16'h9F09};

        reset = 1'b1;
        load_regs();
        bus.wb_data = 16'h0;   bus.wb_enable = 16'h0;
        bus.in_valid = 1'b0;   bus.out_ready = 1'b0;
        bus.src_a = 4'd0;      bus.src_b = 4'd0;      bus.dst_in = 4'd0;
        bus_z.wb_data = 16'h0; bus_z.wb_enable = 16'h0;
        bus_z.in_valid = 1'b0; bus_z.out_ready = 1'b0;
        bus_z.src_a = 4'd0;    bus_z.src_b = 4'd0;    bus_z.dst_in = 4'd0;

        // Reset state
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_op_a", 32'(bus.op_a), 32'd0);
        check("rst_op_b", 32'(bus.op_b), 32'd0);
        check("rst_dst", 32'(bus.dst_out), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        @(negedge clk);
        reset = 1'b0;

        // Basic issue, plus zero-r0 instance with a write aimed at r0
        bus.regs_in[3*16 +: 16] = 16'h1234;
        bus.regs_in[7*16 +: 16] = 16'hBEEF;
        bus.src_a = 4'd3; bus.src_b = 4'd7; bus.dst_in = 4'd9;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        bus_z.regs_in[0*16 +: 16] = 16'hFFFF;
        bus_z.regs_in[1*16 +: 16] = 16'h4321;
        bus_z.wb_enable = 16'h0001; bus_z.wb_data = 16'h1234;
        bus_z.src_a = 4'd0; bus_z.src_b = 4'd1;
        bus_z.in_valid = 1'b1; bus_z.out_ready = 1'b1;
        #1;
        check("issue_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_op_a", 32'(bus.op_a), 32'h1234);
        check("t1_op_b", 32'(bus.op_b), 32'hBEEF);
        check("t1_dst", 32'(bus.dst_out), 32'd9);
        check("t1_in_ready_full", 32'(bus.in_ready), 32'd0);
        check("z_op_a_r0", 32'(bus_z.op_a), 32'h0000);
        check("z_op_b", 32'(bus_z.op_b), 32'h4321);
        bus_z.in_valid = 1'b0;

        // Stall for 3 cycles while the bank and write-back bus move
        bus.regs_in[3*16 +: 16] = 16'h1111;
        bus.regs_in[7*16 +: 16] = 16'h2222;
        bus.wb_enable = 16'h0008; bus.wb_data = 16'hA5A5;
        bus.dst_in = 4'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_op_a", 32'(bus.op_a), 32'h1234);
            check("stall_op_b", 32'(bus.op_b), 32'hBEEF);
            check("stall_dst", 32'(bus.dst_out), 32'd9);
        end
`ifdef OPFETCH_STATS_EN
        check("stall_count", 32'(stall_count), 32'd3);
        check("issue_count_1", 32'(issue_count), 32'd1);
`endif
        // Release: new entry captured on the same edge, r3 forwarded
        bus.regs_in[7*16 +: 16] = 16'hBEEF;
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("fwd_out_valid", 32'(bus.out_valid), 32'd1);
        check("fwd_op_a", 32'(bus.op_a), 32'hA5A5);
        check("fwd_op_b", 32'(bus.op_b), 32'hBEEF);
        check("fwd_dst", 32'(bus.dst_out), 32'd5);

        // Back-to-back issues with out_ready held high
        load_regs();
        for (int k = 0; k < 7; k++) begin
            bus.src_a = v_sa[k]; bus.src_b = v_sb[k]; bus.dst_in = 4'(k);
            bus.wb_enable = v_we[k]; bus.wb_data = v_wd[k];
            #1;
            check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
            @(negedge clk);
            check("b2b_out_valid", 32'(bus.out_valid), 32'd1);
            check("b2b_op_a", 32'(bus.op_a), 32'(v_ea[k]));
            check("b2b_op_b", 32'(bus.op_b), 32'(v_eb[k]));
            check("b2b_dst", 32'(bus.dst_out), 32'(k));
        end

        // Drain, then idle stays empty
        bus.in_valid = 1'b0; bus.wb_enable = 16'h0;
        @(negedge clk);
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset while FULL
        bus.src_a = 4'd3; bus.src_b = 4'd4; bus.dst_in = 4'd11; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("prerst_op_a", 32'(bus.op_a), 32'h3F03);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_op_a", 32'(bus.op_a), 32'd0);
        check("arst_dst", 32'(bus.dst_out), 32'd0);
`ifdef OPFETCH_STATS_EN
        check("arst_issue_count", 32'(issue_count), 32'd0);
        check("arst_stall_count", 32'(stall_count), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

`ifdef OPFETCH_STATS_EN
        // Issue counter wrap
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        repeat (65535) @(negedge clk);
        check("issue_count_max", 32'(issue_count), 32'hFFFF);
        @(negedge clk);
        check("issue_count_wrap", 32'(issue_count), 32'h0000);
        bus.in_valid = 1'b0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read stage directly downstream of the 16x16 register bank. Consumes its sixteen register outputs plus the write-back bus that feeds the bank (ALU bus data and one-hot write enables).
- Selects two source operands per instruction and forwards same-cycle write-back data.
- Holds the result in a one-entry output register with a valid/ready handshake toward the ALU stage.

Parameters:
- DATA_W, 16, register and operand width.
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W = 16.
- ZERO_REG0, 0, when 1 reads of address 0 return zero; forwarding to r0 is also suppressed.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- regs_in  input  NUM_REGS*DATA_W  bank outputs packed {r15,...,r0}; r0 = bits [15:0]
- wb_data  input  DATA_W  data being written to the bank this cycle (ALU bus)
- wb_enable  input  NUM_REGS  one-hot-or-zero write enables presented to the bank this cycle
- in_valid  input  1  issue request valid
- in_ready  output  1  stage can accept an issue this cycle
- src_a  input  ADDR_W  operand A register address
- src_b  input  ADDR_W  operand B register address
- dst_in  input  ADDR_W  destination address, passed through
- out_valid  output  1  op_a/op_b/dst_out valid
- out_ready  input  1  downstream accepts this cycle
- op_a  output  DATA_W  operand A
- op_b  output  DATA_W  operand B
- dst_out  output  ADDR_W  registered dst_in

Behaviour:
- Reset (async assert, sync-to-clk release): out_valid=0, op_a=0, op_b=0, dst_out=0; stats counters=0. Reset mid-operation discards any held entry.
- State machine:
  - EMPTY (out_valid=0): in_valid=1 goes to FULL with capture; otherwise stays EMPTY.
  - FULL (out_valid=1): out_ready=1 with in_valid=1 captures a new entry and stays FULL (back-to-back, one issue per cycle). out_ready=1 with in_valid=0 goes to EMPTY. out_ready=0 holds all outputs stable.
- in_ready = !out_valid || out_ready (combinational). An issue happens when in_valid && in_ready.
- Latency: operands appear on op_a/op_b one cycle after the issue edge.
- Operand value, computed per source address s:
  - if ZERO_REG0 and s==0: value is 0;
  - else if wb_enable[s]: value is wb_data (bypass, since the bank updates on the same edge);
  - else: value is regs_in[s*DATA_W +: DATA_W].
- src_a==src_b is legal; both operands get the identical value.
- Captured operands are snapshots. Writes while FULL and stalled do not modify op_a/op_b.
- Multiple wb_enable bits set: no error. Each enabled address forwards wb_data, consistent with the bank writing all enabled registers.
- in_valid=0 never changes state except through the output drain.

Optional Feature:
- Macro: OPFETCH_STATS_EN.
- When defined, the block adds outputs issue_count[15:0] and stall_count[15:0].
  - issue_count increments on every issue.
  - stall_count increments each cycle with out_valid && !out_ready.
  - Both counters wrap at 0xFFFF to 0x0000 and clear on reset.
- When undefined, neither port nor logic exists; the core behaviour is identical.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W=16, ADDR_W=4, NUM_REGS=16;
  - the reg_addr_t typedef;
  - function onehot_hit(enable, addr).
- One natural sub-module, operand_select: purely combinational address-to-value mux with forward and zero-r0 logic. It is instantiated twice (A and B).
- The handshake register lives in operand_fetch.

Test Plan:
- Reset with regs_in r3=0x1234, r7=0xBEEF; issue src_a=3, src_b=7, dst_in=9 -> next cycle out_valid=1, op_a=0x1234, op_b=0xBEEF, dst_out=9.
- Same issue src_a=3 with wb_enable=0x0008 and wb_data=0xA5A5 in the issue cycle -> op_a=0xA5A5 (forwarded), op_b=0xBEEF.
- FULL with out_ready=0 for 3 cycles while in_valid=1 and regs_in change -> in_ready=0, outputs stay unchanged; out_ready=1 -> new entry captured the same edge.
- Back-to-back: 4 issues with out_ready held at 1 -> 4 consecutive out_valid cycles, no bubbles; in_ready stays 1.
- ZERO_REG0=1: src_a=0 with r0=0xFFFF and wb_enable=0x0001 -> op_a=0x0000.
- Assert reset while FULL -> out_valid=0 and op_a=0 immediately, without a clock; with OPFETCH_STATS_EN, issue_count reads 0; 65536 issues -> issue_count wraps to 0.
